// File: rtl/tone_phase_sequencer.sv
// Note sequencer feeding the sine/frequency ROM: phase accumulator, envelope and signed PCM output.
// Latency: 2 cycles from sample_tick to sample_valid. Requests use ready/valid; note_ready drops while a request is pending.
module tone_phase_sequencer #(
  parameter int BITS       = 6,
  parameter int PHASE_BITS = 20
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            sample_tick,
  input  logic [4:0]      note_in,
  input  logic            note_valid,
  output logic            note_ready,
  output logic [10:0]     index_out,
  output logic [4:0]      freq_id_out,
  input  logic [BITS-1:0] level_in,
  input  logic [15:0]     freq_in,
  output logic [BITS:0]   sample_out,
  output logic            sample_valid,
  output logic            busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PLAY    = 2'd1;
  localparam logic [1:0] SWITCH  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [4:0] SILENCE_ID = 5'd31;

  logic [1:0]            state;
  logic [PHASE_BITS-1:0] phase;
  logic [3:0]            amp;
  logic                  pending;
  logic [4:0]            pending_id;
  logic                  stage1;
  logic                  tick_go;
  logic [PHASE_BITS:0]   phase_sum;
  logic                  phase_wrap;
  logic [PHASE_BITS-1:0] phase_next;
  logic [BITS+3:0]       prod;
  logic [BITS-1:0]       mag;
  logic [BITS:0]         mag_ext;
  logic                  neg;

  // A tick landing while the previous one is still in the ROM stage is dropped.
  assign tick_go    = sample_tick & ~stage1;
  assign phase_sum  = {1'b0, phase} + {{(PHASE_BITS + 1 - 16){1'b0}}, freq_in};
  assign phase_wrap = phase_sum[PHASE_BITS];
  assign phase_next = phase_sum[PHASE_BITS-1:0];

  assign index_out  = {1'b0, phase[PHASE_BITS-1 -: 10]};
  assign note_ready = ~pending;
  assign busy       = (state != IDLE);

  assign prod    = {4'b0000, level_in} * {{BITS{1'b0}}, amp};
  assign mag     = BITS'(prod >> 4);
  assign mag_ext = {1'b0, mag};
  assign neg     = index_out[9];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      phase        <= '0;
      amp          <= 4'd0;
      pending      <= 1'b0;
      pending_id   <= SILENCE_ID;
      stage1       <= 1'b0;
      freq_id_out  <= SILENCE_ID;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      stage1       <= tick_go;
      sample_valid <= stage1;

      if (note_valid && !pending) begin
        pending    <= 1'b1;
        pending_id <= note_in;
      end

      if (tick_go) begin
        case (state)
          IDLE: begin
            if (pending) begin
              pending <= 1'b0;
              if (pending_id != SILENCE_ID) begin
                freq_id_out <= pending_id;
                phase       <= '0;
                amp         <= 4'd1;
                state       <= PLAY;
              end
            end
          end
          PLAY: begin
            phase <= phase_next;
            if (amp != 4'd15) amp <= amp + 4'd1;
            if (pending) begin
              if (pending_id == SILENCE_ID) begin
                pending <= 1'b0;
                state   <= RELEASE;
              end else begin
                state <= SWITCH;
              end
            end
          end
          SWITCH: begin
            // Retune only at the zero crossing of the wrap so the waveform stays continuous.
            if (phase_wrap) begin
              phase       <= '0;
              freq_id_out <= pending_id;
              pending     <= 1'b0;
              state       <= PLAY;
            end else begin
              phase <= phase_next;
            end
          end
          RELEASE: begin
            if (amp <= 4'd1) begin
              amp         <= 4'd0;
              freq_id_out <= SILENCE_ID;
              phase       <= '0;
              state       <= IDLE;
            end else begin
              amp   <= amp - 4'd1;
              phase <= phase_next;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (stage1) begin
        if (state == IDLE) sample_out <= '0;
        else               sample_out <= neg ? -mag_ext : mag_ext;
      end
    end
  end

endmodule

// File: tb/tb_tone_phase_sequencer.sv
// Directed bench for tone_phase_sequencer with a small frequency ROM model driving freq_in.
module tb_tone_phase_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        sample_tick;
  logic [4:0]  note_in;
  logic        note_valid;
  logic        note_ready;
  logic [10:0] index_out;
  logic [4:0]  freq_id_out;
  logic [5:0]  level_in;
  logic [15:0] freq_in;
  logic [6:0]  sample_out;
  logic        sample_valid;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  localparam logic [6:0] S0   = 7'd0;
  localparam logic [6:0] S3   = 7'd3;
  localparam logic [6:0] S7   = 7'd7;
  localparam logic [6:0] S37  = 7'd37;
  localparam logic [6:0] S55  = 7'd55;
  localparam logic [6:0] S59  = 7'd59;
  localparam logic [6:0] SN59 = 7'h45;

  always #5 clk_in = ~clk_in;

  always_comb begin
    case (freq_id_out)
      5'd24:   freq_in = 16'd7268;
      5'd0:    freq_in = 16'd4000;
      5'd5:    freq_in = 16'd20480;
      default: freq_in = 16'd0;
    endcase
  end

  tone_phase_sequencer #(.BITS(6), .PHASE_BITS(20)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .sample_tick  (sample_tick),
    .note_in      (note_in),
    .note_valid   (note_valid),
    .note_ready   (note_ready),
    .index_out    (index_out),
    .freq_id_out  (freq_id_out),
    .level_in     (level_in),
    .freq_in      (freq_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  // One tick; returns at t+2, when the sample for that tick is on the output.
  task automatic do_tick();
    sample_tick = 1'b1;
    @(posedge clk_in); #1;
    sample_tick = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic request(input logic [4:0] id);
    note_in    = id;
    note_valid = 1'b1;
    @(posedge clk_in); #1;
    note_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    vectors++; if (freq_id_out !== 5'd31) begin errors++; $display("FAIL reset_freq_id got %0d want 31", freq_id_out); end
    vectors++; if (index_out !== 11'd0) begin errors++; $display("FAIL reset_index got %0d want 0", index_out); end
    vectors++; if (sample_valid !== 1'b0 || sample_out !== S0) begin errors++; $display("FAIL reset_sample got v=%b s=%0d want v=0 s=0", sample_valid, sample_out); end
    vectors++; if (note_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready_busy got r=%b b=%b want r=1 b=0", note_ready, busy); end
    sample_tick = 1'b1;
    @(posedge clk_in); #1;
    sample_tick = 1'b0;
    vectors++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL idle_valid_t1 got %b want 0", sample_valid); end
    @(posedge clk_in); #1;
    vectors++; if (sample_valid !== 1'b1 || sample_out !== S0) begin errors++; $display("FAIL idle_sample_t2 got v=%b s=%0d want v=1 s=0", sample_valid, sample_out); end
    @(posedge clk_in); #1;
    vectors++; if (sample_valid !== 1'b0 || busy !== 1'b0 || freq_id_out !== 5'd31) begin errors++; $display("FAIL idle_after got v=%b b=%b id=%0d want v=0 b=0 id=31", sample_valid, busy, freq_id_out); end
  endtask

  task automatic test_play();
    request(5'd24);
    vectors++; if (note_ready !== 1'b0) begin errors++; $display("FAIL play_pending_ready got %b want 0", note_ready); end
    do_tick();
    vectors++; if (freq_id_out !== 5'd24 || index_out !== 11'd0) begin errors++; $display("FAIL play_start got id=%0d idx=%0d want id=24 idx=0", freq_id_out, index_out); end
    vectors++; if (sample_out !== S3 || note_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL play_amp1 got s=%0d r=%b b=%b want s=3 r=1 b=1", sample_out, note_ready, busy); end
    do_tick();
    vectors++; if (index_out !== 11'd7 || sample_out !== S7) begin errors++; $display("FAIL play_step2 got idx=%0d s=%0d want idx=7 s=7", index_out, sample_out); end
    for (int i = 0; i < 18; i++) do_tick();
    vectors++; if (index_out !== 11'd134 || sample_out !== S59) begin errors++; $display("FAIL play_amp15 got idx=%0d s=%0d want idx=134 s=59", index_out, sample_out); end
    do_tick();
    vectors++; if (index_out !== 11'd141 || sample_out !== S59) begin errors++; $display("FAIL play_amp_hold got idx=%0d s=%0d want idx=141 s=59", index_out, sample_out); end
  endtask

  task automatic test_switch();
    request(5'd0);
    vectors++; if (note_ready !== 1'b0) begin errors++; $display("FAIL switch_ready got %b want 0", note_ready); end
    do_tick();
    for (int i = 0; i < 123; i++) do_tick();
    vectors++; if (freq_id_out !== 5'd24 || note_ready !== 1'b0) begin errors++; $display("FAIL switch_hold got id=%0d r=%b want id=24 r=0", freq_id_out, note_ready); end
    vectors++; if (index_out !== 11'd1022 || sample_out !== SN59) begin errors++; $display("FAIL switch_neg got idx=%0d s=%0d want idx=1022 s=0x45", index_out, sample_out); end
    do_tick();
    vectors++; if (freq_id_out !== 5'd0 || index_out !== 11'd0 || note_ready !== 1'b1) begin errors++; $display("FAIL switch_wrap got id=%0d idx=%0d r=%b want id=0 idx=0 r=1", freq_id_out, index_out, note_ready); end
    vectors++; if (sample_out !== S59) begin errors++; $display("FAIL switch_amp_held got s=%0d want 59", sample_out); end
  endtask

  task automatic test_release();
    request(5'd31);
    do_tick();
    vectors++; if (sample_out !== S59 || busy !== 1'b1) begin errors++; $display("FAIL release_enter got s=%0d b=%b want s=59 b=1", sample_out, busy); end
    do_tick();
    vectors++; if (index_out !== 11'd7 || sample_out !== S55) begin errors++; $display("FAIL release_amp14 got idx=%0d s=%0d want idx=7 s=55", index_out, sample_out); end
    for (int i = 0; i < 13; i++) do_tick();
    vectors++; if (busy !== 1'b1 || freq_id_out !== 5'd0) begin errors++; $display("FAIL release_amp1 got b=%b id=%0d want b=1 id=0", busy, freq_id_out); end
    do_tick();
    vectors++; if (freq_id_out !== 5'd31 || busy !== 1'b0 || index_out !== 11'd0) begin errors++; $display("FAIL release_done got id=%0d b=%b idx=%0d want id=31 b=0 idx=0", freq_id_out, busy, index_out); end
    vectors++; if (sample_out !== S0 || sample_valid !== 1'b1) begin errors++; $display("FAIL release_sample got s=%0d v=%b want s=0 v=1", sample_out, sample_valid); end
  endtask

  task automatic test_arith();
    level_in = 6'd63;
    request(5'd5);
    do_tick();
    for (int i = 0; i < 30; i++) do_tick();
    vectors++; if (index_out !== 11'd600 || sample_out !== SN59) begin errors++; $display("FAIL arith_600 got idx=%0d s=%0d want idx=600 s=0x45", index_out, sample_out); end
    for (int i = 0; i < 231; i++) do_tick();
    vectors++; if (index_out !== 11'd100 || sample_out !== S59) begin errors++; $display("FAIL arith_100 got idx=%0d s=%0d want idx=100 s=59", index_out, sample_out); end
    level_in = 6'd40;
    do_tick();
    vectors++; if (index_out !== 11'd120 || sample_out !== S37) begin errors++; $display("FAIL arith_lvl40 got idx=%0d s=%0d want idx=120 s=37", index_out, sample_out); end
    level_in = 6'd63;
  endtask

  task automatic test_reset_mid();
    request(5'd0);
    do_tick();
    vectors++; if (note_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_switch got r=%b b=%b want r=0 b=1", note_ready, busy); end
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    vectors++; if (freq_id_out !== 5'd31 || index_out !== 11'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got id=%0d idx=%0d b=%b want id=31 idx=0 b=0", freq_id_out, index_out, busy); end
    vectors++; if (note_ready !== 1'b1 || sample_valid !== 1'b0 || sample_out !== S0) begin errors++; $display("FAIL mid_reset_out got r=%b v=%b s=%0d want r=1 v=0 s=0", note_ready, sample_valid, sample_out); end
    do_tick();
    vectors++; if (freq_id_out !== 5'd31 || busy !== 1'b0 || sample_out !== S0) begin errors++; $display("FAIL mid_discard got id=%0d b=%b s=%0d want id=31 b=0 s=0", freq_id_out, busy, sample_out); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    request(5'd24);
    sample_tick = 1'b1;
    @(posedge clk_in); #1;
    if (sample_valid === 1'b1) pulses++;
    @(posedge clk_in); #1;
    sample_tick = 1'b0;
    if (sample_valid === 1'b1) pulses++;
    vectors++; if (sample_out !== S3 || index_out !== 11'd0) begin errors++; $display("FAIL b2b_first got s=%0d idx=%0d want s=3 idx=0", sample_out, index_out); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in); #1;
      if (sample_valid === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    do_tick();
    vectors++; if (index_out !== 11'd7 || sample_out !== S7) begin errors++; $display("FAIL b2b_ignored got idx=%0d s=%0d want idx=7 s=7", index_out, sample_out); end
  endtask

  initial begin
    rst_in      = 1'b1;
    sample_tick = 1'b0;
    note_in     = 5'd0;
    note_valid  = 1'b0;
    level_in    = 6'd63;
    #1;
    test_reset();
    test_play();
    test_switch();
    test_release();
    test_arith();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
